// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for a shift-add multiplier datapath.
// A rising edge on start runs one multiply: a load cycle, WIDTH
// add/shift iterations, then a one-cycle done pulse. Start edges seen
// while an operation is in flight are dropped. abort cancels an
// operation during LOAD or RUN.
module mult_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mplier_lsb,
    output logic             load,
    output logic             shift,
    output logic             add_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step
);

    // Parameter sanity: at least two iterations, and the counter must hold WIDTH-1.
    if (WIDTH < 2 || (1 << CNT_W) <= WIDTH - 1) begin : g_bad_params
        $error("mult_sequencer: need WIDTH >= 2 and 2**CNT_W > WIDTH-1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             start_edge;

    assign start_edge = start & ~start_q;

    // State, iteration counter and start history register.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of all the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // A start held high through reset must not look like a fresh edge.
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start;
        end
    end

    // Next-state logic; abort overrides every transition out of LOAD and RUN.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort && (state_q == LOAD || state_q == RUN)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Datapath enables decoded from state; add_en also follows the multiplier LSB.
    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        add_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        step   = '0;
        case (state_q)
            LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            RUN: begin
                shift  = 1'b1;
                add_en = mplier_lsb;
                busy   = 1'b1;
                step   = cnt_q;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Testbench for mult_sequencer (WIDTH=4). The driver issues operations
// and pushes one expected transaction per accepted start edge; a
// monitor reconstructs each observed operation from the outputs and
// compares it with the head of the queue.
module tb_mult_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          mplier_lsb;
    logic          load;
    logic          shift;
    logic          add_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] step;

    mult_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mplier_lsb (mplier_lsb),
        .load       (load),
        .shift      (shift),
        .add_en     (add_en),
        .busy       (busy),
        .done       (done),
        .step       (step)
    );

    always #5 clk = ~clk;

    // Cycle numbering: the cycle after edge N is cycle N+1 as seen at negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected operation: when its start edge was sampled, the multiplier
    // bits the driver will present, how many RUN cycles it should last
    // and whether it should end with a done pulse.
    typedef struct {
        int           e0;
        logic [W-1:0] lsb;
        int           nrun;
        bit           done;
    } exp_t;

    exp_t sb_q[$];

    // ---------------- monitor ----------------
    bit           in_op = 1'b0;
    int           obs_n;
    logic [W-1:0] obs_adds;
    bit           steps_ok;
    int           load_cyc;

    task automatic finalize(input bit got_done);
        exp_t         e;
        logic [W-1:0] m_exp;
        logic [W-1:0] m_obs;
        if (sb_q.size() == 0) begin
            check("unexpected_operation", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        m_exp = '0;
        m_obs = '0;
        for (int i = 0; i < W; i++) begin
            if (i < e.nrun) begin
                m_exp[i] = e.lsb[i];
                m_obs[i] = obs_adds[i];
            end
        end
        check("load_latency", load_cyc - e.e0, 1);
        check("run_cycles", obs_n, e.nrun);
        check("done_pulse", got_done, e.done);
        check("add_pattern", m_obs, m_exp);
        check("step_sequence", steps_ok, 1);
        if (got_done) check("done_latency", cyc - e.e0, W + 2);
    endtask

    always @(negedge clk) begin
        check("busy_flag", busy, load | shift);
        if (!shift) check("quiet_outside_run", {add_en, step}, 0);
        if (in_op) begin
            if (shift) begin
                if (step !== CW'(obs_n)) steps_ok = 1'b0;
                if (obs_n < W) obs_adds[obs_n] = add_en;
                obs_n++;
            end else begin
                finalize(done);
                in_op = 1'b0;
            end
        end else if (load) begin
            in_op    = 1'b1;
            obs_n    = 0;
            obs_adds = '0;
            steps_ok = 1'b1;
            load_cyc = cyc;
        end else begin
            check("activity_outside_op", {shift, done}, 0);
        end
    end

    // ---------------- driver ----------------
    // Entered and left at posedge+2. Cycle j of the operation: 0 = LOAD,
    // 1..W = RUN step j-1. abort_j / rst_j pick the cycle in which abort or
    // reset is applied (-1 = never). noise: 0 leave start alone, 1 random
    // start toggles, 2 second rising edge in RUN cycle 3.
    task automatic do_op(input logic [W-1:0] lsb, input int abort_j, input int rst_j,
                         input int noise, output int e0_o);
        exp_t e;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk);
        e0_o   = cyc;
        e.e0   = cyc;
        e.lsb  = lsb;
        e.nrun = (abort_j >= 0) ? abort_j : (rst_j >= 1) ? rst_j - 1 : W;
        e.done = (abort_j < 0) && (rst_j < 0);
        sb_q.push_back(e);
        #2;
        for (int j = 0; j <= W; j++) begin
            mplier_lsb = (j >= 1) ? lsb[j-1] : 1'($urandom_range(0, 1));
            abort      = (j == abort_j);
            if (noise == 1) start = 1'($urandom_range(0, 1));
            if (noise == 2) start = (j >= 3);
            if (j == rst_j) begin
                mplier_lsb = 1'b1;
                reset = 1'b0;
                #1;
                check("reset_outputs_zero", {load, shift, add_en, busy, done, step}, 0);
                @(posedge clk);
                @(posedge clk); #2;
                reset = 1'b1;
                return;
            end
            @(posedge clk); #2;
            if (j == abort_j) begin
                abort = 1'b0;
                return;
            end
        end
    endtask

    // Idle cycles with random abort and multiplier bit; start is held.
    task automatic idle(input int n);
        repeat (n) begin
            abort      = 1'($urandom_range(0, 1));
            mplier_lsb = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
        end
        abort = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           bad;
        int           e0a;
        int           e0b;
        logic [W-1:0] r_lsb;
        int           r_ab;

        // Reset with start held high throughout: nothing may start.
        reset      = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        mplier_lsb = 1'b1;
        @(negedge clk);
        check("reset_state", {load, shift, add_en, busy, done, step}, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (load || busy || done) bad++;
        end
        check("start_held_through_reset", bad, 0);
        @(posedge clk); #2;

        // Basic operation, multiplier LSB sequence 1,0,1,1.
        do_op(4'b1101, -1, -1, 0, e0a);
        idle(2);

        // Second rising edge during RUN is ignored; start stays high after.
        do_op(4'b0110, -1, -1, 2, e0a);
        idle(6);

        // Abort in the RUN cycle with step=2.
        do_op(4'b0111, 3, -1, 0, e0a);
        #1;
        check("after_abort_quiet", {load, shift, busy, done, step}, 0);
        #1;
        idle(2);

        // Abort during LOAD.
        do_op(4'b1111, 0, -1, 0, e0a);
        idle(1);

        // Reset during RUN step 2, then a full operation from step 0.
        do_op(4'b1011, -1, 3, 0, e0a);
        do_op(4'b1010, -1, -1, 0, e0a);

        // Back-to-back: start low in the DONE cycle, high in the first IDLE cycle.
        do_op(4'b0001, -1, -1, 0, e0a);
        do_op(4'b1000, -1, -1, 0, e0b);
        check("back_to_back_gap", e0b - e0a, W + 3);
        idle(3);

        // Randomised operations with random start noise, aborts and gaps.
        for (int k = 0; k < 40; k++) begin
            r_lsb = W'($urandom);
            r_ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
            do_op(r_lsb, r_ab, -1, 1, e0a);
            idle(int'($urandom_range(0, 3)));
        end

        idle(4);
        check("scoreboard_drained", sb_q.size(), 0);
        check("no_open_operation", in_op, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
